fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Pointer and flag controller for the FIFO memory array. It turns producer write requests and consumer read requests into the memory's `wr_en`/`rd_en`/`wr_addr`/`rd_addr` controls, and reports full/empty, almost-full/almost-empty, occupancy and error flags. It sits directly upstream of the memory array, which is configured with PRIORITY = 2'b11 (simultaneous read and write). It also tracks the memory's 1-cycle read latency so the consumer knows when `data_out` is valid.

## Interface
- `WIDTH`, 8, data width (for consistency with the memory; not used in logic)
- `DEPTH`, 16, number of FIFO entries; must equal 2**ADDR_SIZE
- `ADDR_SIZE`, 4, memory index width
- `AF_LEVEL`, 14, `almost_full` asserts when count >= AF_LEVEL
- `AE_LEVEL`, 2, `almost_empty` asserts when count <= AE_LEVEL

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; everything is updated on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr_req`  in  1  producer write request
- `rd_req`  in  1  consumer read request
- `wr_en`  out  1  memory write enable (combinational)
- `rd_en`  out  1  memory read enable (combinational)
- `wr_addr`  out  ADDR_SIZE+1  memory write address; MSB always 0
- `rd_addr`  out  ADDR_SIZE+1  memory read address; MSB always 0
- `full`  out  1  FIFO holds DEPTH entries
- `empty`  out  1  FIFO holds 0 entries
- `almost_full`  out  1  count >= AF_LEVEL
- `almost_empty`  out  1  count <= AE_LEVEL
- `count`  out  ADDR_SIZE+1  occupancy, range 0..DEPTH
- `data_valid`  out  1  memory `data_out` holds the newly read word
- `overflow`  out  1  1-cycle pulse: a write was rejected
- `underflow`  out  1  1-cycle pulse: a read was rejected

## Operation
- **Pointers:** `wptr` and `rptr` are registered and ADDR_SIZE+1 bits wide. The MSB is a wrap bit.
  - `wr_addr` = {1'b0, wptr[ADDR_SIZE-1:0]}; `rd_addr` = {1'b0, rptr[ADDR_SIZE-1:0]}.
  - Forcing the MSB to 0 keeps the memory index within 0..DEPTH-1.
- **Enables:** `wr_en` = wr_req & ~full; `rd_en` = rd_req & ~empty.
- **Pointer update:** on each edge, `wptr` += `wr_en` and `rptr` += `rd_en`, modulo 2**(ADDR_SIZE+1). Natural binary wrap, no saturation.
- **Flags:**
  - `empty` = (wptr == rptr).
  - `full` = (MSBs differ) & (lower bits equal).
  - Both are decoded from the registered pointers, so they are glitch-free and valid from the cycle after the update.
- **Count:** registered. +1 on write only, −1 on read only, unchanged when both or neither happen. It always equals wptr − rptr (mod 2**(ADDR_SIZE+1)).
- **Almost flags:** `almost_full` and `almost_empty` are compared against the registered `count`.
- **Simultaneous wr_req & rd_req:**
  - Not full and not empty: both are accepted; count is unchanged.
  - Empty: only the write is accepted; `underflow` pulses.
  - Full: the read is accepted and the write is rejected; `overflow` pulses. Count becomes DEPTH−1.
- **Rejected requests:** `overflow` is registered, set for one cycle after an edge where wr_req & full. `underflow` is registered, set for one cycle after an edge where rd_req & empty. Rejected requests never move a pointer.
- **Read tracking:** `data_valid` is registered and equals the previous cycle's `rd_en`, matching the memory's registered read.
- **Reset** (rst=1 at an edge): wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, data_valid=0, overflow=0, underflow=0.
  - Mid-operation reset discards all contents. `wr_en`/`rd_en` still follow the request inputs combinationally during reset; they are don't-care at the memory, since its read is blocked by its own reset.

## Timing
- **Write:** wr_req high in cycle N with full=0 → `wr_en` high in cycle N, the memory writes at edge N+1, and `empty` falls after edge N+1.
- **Read:** rd_req high in cycle N with empty=0 → `rd_en` and `rd_addr` valid in cycle N. `data_out` and `data_valid`=1 appear after edge N+1, i.e. 1-cycle read latency.
- **Flag latency:** full, empty, count, almost_* and error pulses all change exactly 1 edge after the causing request.
- **Throughput:** one write and one read per cycle sustained.
- **Back-to-back reads:** these return consecutive entries every cycle; `data_valid` stays high continuously.

## Test plan
- **Reset:** hold rst for 2 cycles with random requests → count=0, empty=1, full=0, almost_empty=1, all pulses 0, wr_addr=rd_addr=0.
- **Fill:** 16 writes of 0x00..0x0F → full=1 after the 16th edge, count=16, almost_full from count=14. A 17th wr_req gives wr_en=0 and an overflow pulse of exactly 1 cycle; wptr is unchanged.
- **Drain:** 16 reads → `data_out` 0x00..0x0F in order, `data_valid` high 16 cycles, empty=1 at the end. A 17th rd_req gives rd_en=0 and an underflow pulse.
- **Simultaneous events:**
  - At full, wr_req & rd_req → read accepted, overflow=1, count=15.
  - At empty, wr_req & rd_req → write accepted, underflow=1, count=1.
  - At count=5, both requests → count stays 5.
- **Wrap-around:** write 10, read 10, then write 16 → wr_addr sequence 10..15, 0..9 with MSB=0, full=1. Reading back returns all 16 values in order.
- **Reset mid-operation:** at count=7, assert rst for 1 cycle → count=0, empty=1. A subsequent write lands at address 0 and reads back correctly.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller sitting in front of a FIFO memory with simultaneous read/write.
// Wrap-bit pointers decode full/empty; a separate registered count drives occupancy and the almost flags.
module fifo_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_SIZE = 4,
  parameter int AF_LEVEL  = 14,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_req,
  input  logic                 rd_req,
  output logic                 wr_en,
  output logic                 rd_en,
  output logic [ADDR_SIZE:0]   wr_addr,
  output logic [ADDR_SIZE:0]   rd_addr,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 data_valid,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int              PW     = ADDR_SIZE + 1;
  localparam logic [PW-1:0]   ONE    = PW'(1);
  localparam logic [PW-1:0]   AF_THR = PW'(AF_LEVEL);
  localparam logic [PW-1:0]   AE_THR = PW'(AE_LEVEL);

  // Elaboration-time sanity: the wrap-bit scheme only works for a power-of-two depth.
  if (DEPTH != (1 << ADDR_SIZE)) begin : g_bad_depth
    $error("fifo_ctrl: DEPTH must equal 2**ADDR_SIZE");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_ctrl: WIDTH must be at least 1");
  end

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          data_valid_q, data_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[ADDR_SIZE] != rptr_q[ADDR_SIZE]) &&
              (wptr_q[ADDR_SIZE-1:0] == rptr_q[ADDR_SIZE-1:0]);
    wr_en   = wr_req & ~full;
    rd_en   = rd_req & ~empty;
    wr_addr = {1'b0, wptr_q[ADDR_SIZE-1:0]};
    rd_addr = {1'b0, rptr_q[ADDR_SIZE-1:0]};
  end

  always_comb begin
    wptr_d       = wr_en ? wptr_q + ONE : wptr_q;
    rptr_d       = rd_en ? rptr_q + ONE : rptr_q;
    count_d      = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
    data_valid_d = rd_en;
    overflow_d   = wr_req & full;
    underflow_d  = rd_req & empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= AF_THR);
  assign almost_empty = (count_q <= AE_THR);
  assign data_valid   = data_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: a small behavioural memory plus a queue-based FIFO model.
// Each scenario task drives requests and checks the controller against the model.
module tb_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic       clk = 1'b0;
  logic       rst, wr_req, rd_req;
  logic [7:0] wr_data;
  logic       wr_en, rd_en, full, empty, almost_full, almost_empty;
  logic       data_valid, overflow, underflow;
  logic [4:0] wr_addr, rd_addr, count;

  always #5 clk = ~clk;

  fifo_ctrl #(.WIDTH(8), .DEPTH(DEPTH), .ADDR_SIZE(AW), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req),
    .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .data_valid(data_valid), .overflow(overflow), .underflow(underflow)
  );

  // Memory array driven by the controller's enables and addresses, 1-cycle read.
  logic [7:0] mem [DEPTH];
  logic [7:0] data_out;
  always @(posedge clk) begin
    if (rst) data_out <= 8'h00;
    else begin
      if (wr_en) mem[wr_addr[AW-1:0]] <= wr_data;
      if (rd_en) data_out <= mem[rd_addr[AW-1:0]];
    end
  end

  // Reference model: occupancy is the queue, addresses are accepted-op totals mod DEPTH.
  logic [7:0]  q[$];
  int unsigned wcnt, rcnt;
  bit          exp_ovf, exp_unf, exp_dv;
  logic [7:0]  exp_data;
  bit          exp_wr_en, exp_rd_en, obs_wr_en, obs_rd_en;
  logic [4:0]  exp_wr_addr, exp_rd_addr, obs_wr_addr, obs_rd_addr;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic do_cycle();
    int sz;
    @(negedge clk);
    sz          = q.size();
    exp_wr_en   = wr_req && (sz < DEPTH);
    exp_rd_en   = rd_req && (sz > 0);
    exp_wr_addr = 5'(wcnt % DEPTH);
    exp_rd_addr = 5'(rcnt % DEPTH);
    obs_wr_en   = wr_en;
    obs_rd_en   = rd_en;
    obs_wr_addr = wr_addr;
    obs_rd_addr = rd_addr;
    @(posedge clk);
    if (rst) begin
      q.delete();
      wcnt = 0; rcnt = 0;
      exp_ovf = 0; exp_unf = 0; exp_dv = 0;
    end else begin
      exp_ovf = wr_req && (sz == DEPTH);
      exp_unf = rd_req && (sz == 0);
      exp_dv  = exp_rd_en;
      if (exp_rd_en) begin exp_data = q.pop_front(); rcnt++; end
      if (exp_wr_en) begin q.push_back(wr_data); wcnt++; end
    end
    #1;
  endtask

  task automatic drive(input bit w, input bit r, input logic [7:0] d);
    wr_req = w; rd_req = r; wr_data = d;
    do_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) drive(1'($urandom), 1'($urandom), 8'($urandom));
    rst = 1'b0;
    n_cmp++;
    if ({count, empty, full, almost_empty, almost_full} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_flags: got count=%0d e=%b f=%b ae=%b af=%b, need 0 1 0 1 0",
               count, empty, full, almost_empty, almost_full);
    end
    n_cmp++;
    if ({overflow, underflow, data_valid, wr_addr, rd_addr} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_pulses_addr: got ovf=%b unf=%b dv=%b wa=%0d ra=%0d, need all 0",
               overflow, underflow, data_valid, wr_addr, rd_addr);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      n_cmp++;
      if (obs_wr_en !== 1'b1 || count !== 5'(i + 1) || almost_full !== (i + 1 >= 14) ||
          full !== (i + 1 == DEPTH) || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: got we=%b count=%0d af=%b f=%b e=%b, need we=1 count=%0d af=%b f=%b e=0",
                 i, obs_wr_en, count, almost_full, full, empty, i + 1, (i + 1 >= 14), (i + 1 == DEPTH));
      end
    end
    drive(1'b1, 1'b0, 8'hEE);
    n_cmp++;
    if (obs_wr_en !== 1'b0 || overflow !== 1'b1 || wr_addr !== 5'd0 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL fill_overflow: got we=%b ovf=%b wa=%0d count=%0d, need we=0 ovf=1 wa=0 count=16",
               obs_wr_en, overflow, wr_addr, count);
    end
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_ovf_one_cycle: got ovf=%b, need 0", overflow);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if (obs_rd_en !== 1'b1 || data_valid !== 1'b1 || data_out !== 8'(i) ||
          count !== 5'(DEPTH - 1 - i) || almost_empty !== (DEPTH - 1 - i <= 2)) begin
        n_fail++;
        $display("FAIL drain_%0d: got re=%b dv=%b data=%h count=%0d ae=%b, need re=1 dv=1 data=%h count=%0d",
                 i, obs_rd_en, data_valid, data_out, count, almost_empty, 8'(i), DEPTH - 1 - i);
      end
    end
    drive(1'b0, 1'b1, 8'h00);
    n_cmp++;
    if (obs_rd_en !== 1'b0 || underflow !== 1'b1 || empty !== 1'b1 || data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_underflow: got re=%b unf=%b e=%b dv=%b, need re=0 unf=1 e=1 dv=0",
               obs_rd_en, underflow, empty, data_valid);
    end
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_unf_one_cycle: got unf=%b, need 0", underflow);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 8'(8'h30 + i));
    drive(1'b1, 1'b1, 8'hBB);
    n_cmp++;
    if (obs_rd_en !== 1'b1 || obs_wr_en !== 1'b0 || overflow !== 1'b1 || count !== 5'd15 ||
        data_out !== 8'h30) begin
      n_fail++;
      $display("FAIL simul_full: got re=%b we=%b ovf=%b count=%0d data=%h, need re=1 we=0 ovf=1 count=15 data=30",
               obs_rd_en, obs_wr_en, overflow, count, data_out);
    end
    while (q.size() > 0) drive(1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 8'hC1);
    n_cmp++;
    if (obs_wr_en !== 1'b1 || obs_rd_en !== 1'b0 || underflow !== 1'b1 || count !== 5'd1) begin
      n_fail++;
      $display("FAIL simul_empty: got we=%b re=%b unf=%b count=%0d, need we=1 re=0 unf=1 count=1",
               obs_wr_en, obs_rd_en, underflow, count);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'hD0 + i));
    drive(1'b1, 1'b1, 8'hE5);
    n_cmp++;
    if (count !== 5'd5 || obs_wr_en !== 1'b1 || obs_rd_en !== 1'b1 || data_out !== 8'hC1 ||
        data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_mid: got count=%0d we=%b re=%b data=%h dv=%b, need count=5 we=1 re=1 data=c1 dv=1",
               count, obs_wr_en, obs_rd_en, data_out, data_valid);
    end
    while (q.size() > 0) drive(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_wrap();
    rst = 1'b1; drive(1'b0, 1'b0, 8'h00); rst = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 8'(8'h80 + i));
      n_cmp++;
      if (obs_wr_addr !== 5'((10 + i) % DEPTH) || obs_wr_en !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_addr_%0d: got wa=%0d we=%b, need wa=%0d we=1",
                 i, obs_wr_addr, obs_wr_en, (10 + i) % DEPTH);
      end
    end
    n_cmp++;
    if (full !== 1'b1 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL wrap_full: got f=%b count=%0d, need f=1 count=16", full, count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if (data_out !== 8'(8'h80 + i) || obs_rd_addr !== 5'((10 + i) % DEPTH)) begin
        n_fail++;
        $display("FAIL wrap_read_%0d: got data=%h ra=%0d, need data=%h ra=%0d",
                 i, data_out, obs_rd_addr, 8'(8'h80 + i), (10 + i) % DEPTH);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 8'(8'h60 + i));
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 8'h00);
    n_cmp++;
    if (count !== 5'd7) begin
      n_fail++;
      $display("FAIL midrst_pre: got count=%0d, need 7", count);
    end
    rst = 1'b1; drive(1'b0, 1'b0, 8'h00); rst = 1'b0;
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_flags: got count=%0d e=%b f=%b, need 0 1 0", count, empty, full);
    end
    drive(1'b1, 1'b0, 8'hA5);
    n_cmp++;
    if (obs_wr_addr !== 5'd0 || obs_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_waddr: got wa=%0d we=%b, need wa=0 we=1", obs_wr_addr, obs_wr_en);
    end
    drive(1'b0, 1'b1, 8'h00);
    n_cmp++;
    if (data_out !== 8'hA5 || data_valid !== 1'b1 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_read: got data=%h dv=%b e=%b, need a5 1 1", data_out, data_valid, empty);
    end
  endtask

  task automatic test_random();
    bit         w, r;
    int         mode;
    logic [6:0] obs_flags, exp_flags;
    for (int i = 0; i < 600; i++) begin
      mode = (i / 40) % 3;
      case (mode)
        0:       begin w = ($urandom_range(0, 99) < 80); r = ($urandom_range(0, 99) < 25); end
        1:       begin w = ($urandom_range(0, 99) < 25); r = ($urandom_range(0, 99) < 80); end
        default: begin w = 1'($urandom); r = 1'($urandom); end
      endcase
      rst = ($urandom_range(0, 99) == 0);
      drive(w, r, 8'($urandom));
      rst = 1'b0;
      exp_flags = {q.size() == DEPTH, q.size() == 0, q.size() >= 14, q.size() <= 2,
                   exp_ovf, exp_unf, exp_dv};
      obs_flags = {full, empty, almost_full, almost_empty, overflow, underflow, data_valid};
      n_cmp++;
      if (obs_wr_en !== exp_wr_en || obs_rd_en !== exp_rd_en || obs_wr_addr !== exp_wr_addr ||
          obs_rd_addr !== exp_rd_addr) begin
        n_fail++;
        $display("FAIL rand_ctrl_%0d: got we=%b re=%b wa=%0d ra=%0d, need we=%b re=%b wa=%0d ra=%0d",
                 i, obs_wr_en, obs_rd_en, obs_wr_addr, obs_rd_addr,
                 exp_wr_en, exp_rd_en, exp_wr_addr, exp_rd_addr);
      end
      n_cmp++;
      if (obs_flags !== exp_flags || count !== 5'(q.size())) begin
        n_fail++;
        $display("FAIL rand_flags_%0d: got f/e/af/ae/ovf/unf/dv=%b count=%0d, need %b count=%0d",
                 i, obs_flags, count, exp_flags, q.size());
      end
      if (exp_dv) begin
        n_cmp++;
        if (data_out !== exp_data) begin
          n_fail++;
          $display("FAIL rand_data_%0d: got %h, need %h", i, data_out, exp_data);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
    wcnt = 0; rcnt = 0; exp_ovf = 0; exp_unf = 0; exp_dv = 0; exp_data = 8'h00;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
